csr_file: RTL and testbench

Parametrised machine-mode CSR file for the RV32 core, successor to the single-hart CSR block. All state updates are clocked. It adds:
- configurable hart ID, MISA value, PMP entry count and counter width;
- free-running mcycle/minstret counters;
- hardware trap entry and mret stacking of mstatus;
- vectored mtvec;
- interrupt-pending arbitration.

It sits beside the execute stage. It serves CSR instructions and receives trap and mret events from the exception unit.

---
 rtl/csr_file.sv | 231 +++++++++++++++++++++++
 tb/tb_csr_file.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for an RV32 hart. Serves CSR read/modify/write
// instructions, runs mcycle/minstret, stacks mstatus on trap entry and mret, and
// reports the highest-priority enabled interrupt.
module csr_file #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
    parameter int          N_PMP      = 4,
    parameter int          CNT_W      = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        is_csr_i,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] addr_i,
    input  logic [4:0]  rs1_i,
    input  logic [31:0] data_i,
    input  logic        retire_i,
    input  logic        trap_i,
    input  logic        mret_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic [2:0]  irq_i,
    output logic [31:0] data_o,
    output logic        e_illegal_o,
    output logic [31:0] trap_vector_o,
    output logic        int_pending_o,
    output logic [31:0] int_cause_o
);
    localparam int N_CFG = (N_PMP - 1) / 4 + 1;

    localparam logic [11:0] A_MVENDORID  = 12'hF11;
    localparam logic [11:0] A_MARCHID    = 12'hF12;
    localparam logic [11:0] A_MIMPID     = 12'hF13;
    localparam logic [11:0] A_MHARTID    = 12'hF14;
    localparam logic [11:0] A_MSTATUS    = 12'h300;
    localparam logic [11:0] A_MISA       = 12'h301;
    localparam logic [11:0] A_MEDELEG    = 12'h302;
    localparam logic [11:0] A_MIDELEG    = 12'h303;
    localparam logic [11:0] A_MIE        = 12'h304;
    localparam logic [11:0] A_MTVEC      = 12'h305;
    localparam logic [11:0] A_MCOUNTEREN = 12'h306;
    localparam logic [11:0] A_MSCRATCH   = 12'h340;
    localparam logic [11:0] A_MEPC       = 12'h341;
    localparam logic [11:0] A_MCAUSE     = 12'h342;
    localparam logic [11:0] A_MTVAL      = 12'h343;
    localparam logic [11:0] A_MIP        = 12'h344;
    localparam logic [11:0] A_SATP       = 12'h180;
    localparam logic [11:0] A_PMPCFG0    = 12'h3A0;
    localparam logic [11:0] A_PMPADDR0   = 12'h3B0;
    localparam logic [11:0] A_MCYCLE     = 12'hB00;
    localparam logic [11:0] A_MINSTRET   = 12'hB02;
    localparam logic [11:0] A_MCYCLEH    = 12'hB80;
    localparam logic [11:0] A_MINSTRETH  = 12'hB82;

    logic             mie_q, mpie_q;
    logic [29:0]      tvec_base_q;
    logic             tvec_mode_q;
    logic [31:0]      mepc_q, mcause_q, mtval_q, mscratch_q;
    logic [31:0]      medeleg_q, mideleg_q, mcounteren_q, satp_q;
    logic [2:0]       irq_en_q;   // {meie, mtie, msie}
    logic [2:0]       irq_q;      // {meip, mtip, msip}
    logic [CNT_W-1:0] mcycle_q, minstret_q;
    logic [31:0]      pmpcfg_q  [N_CFG];
    logic [31:0]      pmpaddr_q [N_PMP];

    logic [31:0] rdata, src, wdata;
    logic        hit, wr_req, we;
    logic [2:0]  pend;

    // Read mux: current value of the addressed CSR and whether it exists.
    // NOTE: every variable of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (addr_i)
            A_MVENDORID, A_MARCHID, A_MIMPID: rdata = '0;
            A_MHARTID:    rdata = HART_ID;
            A_MISA:       rdata = MISA_VALUE;
            A_MSTATUS:    rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            A_MEDELEG:    rdata = medeleg_q;
            A_MIDELEG:    rdata = mideleg_q;
            A_MIE:        rdata = {20'b0, irq_en_q[2], 3'b0, irq_en_q[1], 3'b0, irq_en_q[0], 3'b0};
            A_MTVEC:      rdata = {tvec_base_q, 1'b0, tvec_mode_q};
            A_MCOUNTEREN: rdata = mcounteren_q;
            A_MSCRATCH:   rdata = mscratch_q;
            A_MEPC:       rdata = mepc_q;
            A_MCAUSE:     rdata = mcause_q;
            A_MTVAL:      rdata = mtval_q;
            A_MIP:        rdata = {20'b0, irq_q[2], 3'b0, irq_q[1], 3'b0, irq_q[0], 3'b0};
            A_SATP:       rdata = satp_q;
            A_MCYCLE:     rdata = mcycle_q[31:0];
            A_MCYCLEH:    rdata = 32'(mcycle_q[CNT_W-1:32]);
            A_MINSTRET:   rdata = minstret_q[31:0];
            A_MINSTRETH:  rdata = 32'(minstret_q[CNT_W-1:32]);
            default:      hit = 1'b0;
        endcase
        for (int i = 0; i < N_CFG; i++) begin
            if (addr_i == A_PMPCFG0 + 12'(i)) begin
                rdata = pmpcfg_q[i];
                hit   = 1'b1;
            end
        end
        for (int i = 0; i < N_PMP; i++) begin
            if (addr_i == A_PMPADDR0 + 12'(i)) begin
                rdata = pmpaddr_q[i];
                hit   = 1'b1;
            end
        end
    end

    // Modified value for CSRRW/CSRRS/CSRRC; the immediate form carries only the 5-bit zimm.
    always_comb begin
        src = funct3_i[2] ? {27'b0, data_i[4:0]} : data_i;
        case (funct3_i[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = rdata | src;
            2'b11:   wdata = rdata & ~src;
            default: wdata = rdata;
        endcase
    end

    // Set/clear with a zero source register never writes, so it is legal on read-only CSRs.
    assign wr_req      = (funct3_i[1:0] == 2'b01) || (rs1_i != 5'd0);
    assign e_illegal_o = is_csr_i && (!hit || (funct3_i[1:0] == 2'b00) ||
                                      ((addr_i[11:10] == 2'b11) && wr_req));
    assign we          = is_csr_i && !e_illegal_o && wr_req && !trap_i && !mret_i;
    assign data_o      = is_csr_i ? rdata : '0;

    // Interrupt lines are registered once before they reach mip.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) irq_q <= '0;
        else       irq_q <= irq_i;
    end

    // Free-running counters; a same-cycle CSR write to either half wins over the increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q <= mcycle_q + CNT_W'(1);
            if (retire_i) minstret_q <= minstret_q + CNT_W'(1);
            if (we && addr_i == A_MCYCLE)    mcycle_q   <= {mcycle_q[CNT_W-1:32], wdata};
            if (we && addr_i == A_MCYCLEH)   mcycle_q   <= {wdata[CNT_W-33:0], mcycle_q[31:0]};
            if (we && addr_i == A_MINSTRET)  minstret_q <= {minstret_q[CNT_W-1:32], wdata};
            if (we && addr_i == A_MINSTRETH) minstret_q <= {wdata[CNT_W-33:0], minstret_q[31:0]};
        end
    end

    // Trap entry, then mret, then CSR instruction writes, in falling priority.
    // NOTE: the PMP arrays are reset like every other CSR, so they build as flops, not RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            tvec_base_q  <= '0;
            tvec_mode_q  <= 1'b0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mscratch_q   <= '0;
            medeleg_q    <= '0;
            mideleg_q    <= '0;
            mcounteren_q <= '0;
            satp_q       <= '0;
            irq_en_q     <= '0;
            for (int i = 0; i < N_CFG; i++) pmpcfg_q[i]  <= '0;
            for (int i = 0; i < N_PMP; i++) pmpaddr_q[i] <= '0;
        end else if (trap_i) begin
            mepc_q   <= trap_pc_i & 32'hFFFF_FFFC;
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_tval_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (we) begin
            case (addr_i)
                A_MSTATUS: begin
                    mie_q  <= wdata[3];
                    mpie_q <= wdata[7];
                end
                A_MTVEC: begin
                    tvec_base_q <= wdata[31:2];
                    tvec_mode_q <= wdata[0];
                end
                A_MIE:        irq_en_q     <= {wdata[11], wdata[7], wdata[3]};
                A_MEPC:       mepc_q       <= wdata & 32'hFFFF_FFFC;
                A_MCAUSE:     mcause_q     <= wdata;
                A_MTVAL:      mtval_q      <= wdata;
                A_MSCRATCH:   mscratch_q   <= wdata;
                A_MEDELEG:    medeleg_q    <= wdata;
                A_MIDELEG:    mideleg_q    <= wdata;
                A_MCOUNTEREN: mcounteren_q <= wdata;
                A_SATP:       satp_q       <= wdata;
                default: ;
            endcase
            for (int i = 0; i < N_CFG; i++)
                if (addr_i == A_PMPCFG0 + 12'(i)) pmpcfg_q[i] <= wdata;
            for (int i = 0; i < N_PMP; i++)
                if (addr_i == A_PMPADDR0 + 12'(i)) pmpaddr_q[i] <= wdata;
        end
    end

    // Trap target: mepc on mret, otherwise direct or vectored mtvec.
    always_comb begin
        if (mret_i)
            trap_vector_o = mepc_q;
        else if (tvec_mode_q && trap_cause_i[31])
            trap_vector_o = {tvec_base_q, 2'b00} + {25'b0, trap_cause_i[4:0], 2'b00};
        else
            trap_vector_o = {tvec_base_q, 2'b00};
    end

    assign pend          = irq_q & irq_en_q;
    assign int_pending_o = mie_q && (pend != 3'b000);

    // Interrupt arbitration: external beats software beats timer.
    always_comb begin
        int_cause_o = '0;
        if (int_pending_o) begin
            if (pend[2])      int_cause_o = 32'h8000_000B;
            else if (pend[0]) int_cause_o = 32'h8000_0003;
            else              int_cause_o = 32'h8000_0007;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed checks of the main CSR behaviours followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_csr_file;
    localparam logic [31:0]     HART  = 32'd3;
    localparam logic [31:0]     MISA  = 32'h4000_0100;
    localparam int              NPMP  = 4;
    localparam int              CW    = 40;
    localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        is_csr_i;
    logic [2:0]  funct3_i;
    logic [11:0] addr_i;
    logic [4:0]  rs1_i;
    logic [31:0] data_i;
    logic        retire_i, trap_i, mret_i;
    logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
    logic [2:0]  irq_i;
    logic [31:0] data_o, trap_vector_o, int_cause_o;
    logic        e_illegal_o, int_pending_o;

    always #5 clk = ~clk;

    csr_file #(.HART_ID(HART), .MISA_VALUE(MISA), .N_PMP(NPMP), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .is_csr_i(is_csr_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .rs1_i(rs1_i), .data_i(data_i), .retire_i(retire_i),
        .trap_i(trap_i), .mret_i(mret_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .irq_i(irq_i),
        .data_o(data_o), .e_illegal_o(e_illegal_o), .trap_vector_o(trap_vector_o),
        .int_pending_o(int_pending_o), .int_cause_o(int_cause_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each CSR is a 32-bit value with a write mask; counters are plain integers mod 2^CW.
    bit [31:0]       regs  [bit [11:0]];
    bit [31:0]       wmask [bit [11:0]];
    longint unsigned cyc, ins;
    bit              model_live = 1'b0;
    logic [11:0]     addr_pool[$];
    logic [11:0]     bad_pool[$];

    function automatic void model_reset();
        regs.delete();
        wmask.delete();
        regs[12'hF11] = 0; regs[12'hF12] = 0; regs[12'hF13] = 0; regs[12'hF14] = HART;
        regs[12'h300] = 32'h1800; regs[12'h301] = MISA;
        regs[12'h302] = 0; regs[12'h303] = 0; regs[12'h304] = 0; regs[12'h305] = 0;
        regs[12'h306] = 0; regs[12'h340] = 0; regs[12'h341] = 0; regs[12'h342] = 0;
        regs[12'h343] = 0; regs[12'h344] = 0; regs[12'h180] = 0; regs[12'h3A0] = 0;
        for (int i = 0; i < NPMP; i++) regs[12'h3B0 + 12'(i)] = 0;
        foreach (regs[a]) wmask[a] = 32'hFFFF_FFFF;
        wmask[12'h300] = 32'h0000_0088;
        wmask[12'h301] = 32'h0;
        wmask[12'h304] = 32'h0000_0888;
        wmask[12'h305] = 32'hFFFF_FFFD;
        wmask[12'h341] = 32'hFFFF_FFFC;
        wmask[12'h344] = 32'h0;
        cyc = 0;
        ins = 0;
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a, output bit ok);
        ok = 1'b1;
        case (a)
            12'hB00: return cyc[31:0];
            12'hB80: return cyc[63:32];
            12'hB02: return ins[31:0];
            12'hB82: return ins[63:32];
            default: begin
                if (regs.exists(a)) return regs[a];
                ok = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    // Expected read data, illegal flag, write enable and new value for the current inputs.
    function automatic void m_comb(output bit [31:0] rd, output bit ill, output bit we,
                                   output bit [31:0] nv);
        bit        ok, wr;
        bit [31:0] old;
        old = m_read(addr_i, ok);
        wr  = (funct3_i[1:0] == 2'b01) || (rs1_i != 5'd0);
        ill = is_csr_i && (!ok || funct3_i[1:0] == 2'b00 || (addr_i[11:10] == 2'b11 && wr));
        rd  = is_csr_i ? old : 32'h0;
        we  = is_csr_i && !ill && wr && !trap_i && !mret_i;
        case (funct3_i[1:0])
            2'b01:   nv = data_i;
            2'b10:   nv = old | data_i;
            2'b11:   nv = old & ~data_i;
            default: nv = old;
        endcase
    endfunction

    function automatic bit [31:0] m_tvec();
        bit [31:0] tv;
        tv = regs[12'h305];
        if (mret_i) return regs[12'h341];
        if (tv[0] && trap_cause_i[31]) return (tv & ~32'h3) + 32'(trap_cause_i[4:0]) * 32'd4;
        return tv & ~32'h3;
    endfunction

    function automatic bit m_pending();
        bit [31:0] ms;
        ms = regs[12'h300];
        return ms[3] && ((regs[12'h344] & regs[12'h304]) != 32'h0);
    endfunction

    function automatic bit [31:0] m_cause();
        bit [31:0] pm;
        pm = regs[12'h344] & regs[12'h304];
        if (!m_pending()) return 32'h0;
        if (pm[11]) return 32'h8000_000B;
        if (pm[3])  return 32'h8000_0003;
        return 32'h8000_0007;
    endfunction

    function automatic void model_step();
        bit [31:0]       rd, nv, ms;
        bit              ill, we;
        longint unsigned cyc0, ins0;
        m_comb(rd, ill, we, nv);
        ms   = regs[12'h300];
        cyc0 = cyc;
        ins0 = ins;
        cyc  = (cyc0 + 1) & CMASK;
        if (retire_i) ins = (ins0 + 1) & CMASK;
        if (we) begin
            case (addr_i)
                12'hB00: cyc = (cyc0 & ~64'hFFFF_FFFF) | 64'(nv);
                12'hB80: cyc = ((64'(nv) << 32) | (cyc0 & 64'hFFFF_FFFF)) & CMASK;
                12'hB02: ins = (ins0 & ~64'hFFFF_FFFF) | 64'(nv);
                12'hB82: ins = ((64'(nv) << 32) | (ins0 & 64'hFFFF_FFFF)) & CMASK;
                default: regs[addr_i] = (regs[addr_i] & ~wmask[addr_i]) | (nv & wmask[addr_i]);
            endcase
        end
        if (trap_i) begin
            regs[12'h341] = trap_pc_i & ~32'h3;
            regs[12'h342] = trap_cause_i;
            regs[12'h343] = trap_tval_i;
            regs[12'h300] = 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
        end else if (mret_i) begin
            regs[12'h300] = 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
        end
        regs[12'h344] = (32'(irq_i[2]) << 11) | (32'(irq_i[1]) << 7) | (32'(irq_i[0]) << 3);
    endfunction

    // Model advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst_i) begin
            model_reset();
            model_live = 1'b1;
        end else if (model_live) begin
            model_step();
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        bit [31:0] rd, nv;
        bit        ill, we;
        if (model_live) begin
            m_comb(rd, ill, we, nv);
            check("data_o", data_o, rd);
            check("e_illegal_o", 32'(e_illegal_o), 32'(ill));
            check("trap_vector_o", trap_vector_o, m_tvec());
            check("int_pending_o", 32'(int_pending_o), 32'(m_pending()));
            check("int_cause_o", int_cause_o, m_cause());
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        is_csr_i = 1'b0; funct3_i = 3'b0; addr_i = 12'h0; rs1_i = 5'd0; data_i = 32'h0;
        retire_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
        trap_cause_i = 32'h0; trap_pc_i = 32'h0; trap_tval_i = 32'h0;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r,
                          input logic [31:0] d);
        is_csr_i = 1'b1; funct3_i = f3; addr_i = a; rs1_i = r; data_i = d;
    endtask

    task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        trap_i = 1'b1; trap_cause_i = cause; trap_pc_i = pc; trap_tval_i = tval;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_op(3'b010, a, 5'd0, 32'h0);
        @(negedge clk);
        check(name, data_o, exp);
        next();
    endtask

    task automatic rnd_cycle();
        logic [2:0]  f3;
        logic [4:0]  r;
        logic [11:0] a;
        rst_i = ($urandom_range(99) == 0);
        if ($urandom_range(9) < 7) begin
            if ($urandom_range(9) == 0) a = bad_pool[$urandom_range(bad_pool.size() - 1)];
            else                        a = addr_pool[$urandom_range(addr_pool.size() - 1)];
            f3 = 3'($urandom_range(7));
            r  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            csr_op(f3, a, r, f3[2] ? 32'(r) : $urandom());
        end
        retire_i     = 1'($urandom_range(1));
        trap_i       = ($urandom_range(11) == 0);
        mret_i       = ($urandom_range(11) == 0);
        trap_cause_i = {1'($urandom_range(1)), 26'($urandom()), 5'($urandom())};
        trap_pc_i    = $urandom();
        trap_tval_i  = $urandom();
        if ($urandom_range(4) == 0) irq_i = 3'($urandom_range(7));
    endtask

    initial begin
        idle();
        irq_i = 3'b000;
        rst_i = 1'b1;
        model_reset();
        foreach (regs[a]) addr_pool.push_back(a);
        addr_pool.push_back(12'hB00); addr_pool.push_back(12'hB80);
        addr_pool.push_back(12'hB02); addr_pool.push_back(12'hB82);
        bad_pool = '{12'h7C0, 12'h3A1, 12'h3B4, 12'h3BF, 12'h001, 12'hB01, 12'hF15};
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state and identity registers.
        csr_op(3'b010, 12'hF14, 5'd0, 32'h0);
        @(negedge clk);
        check("mhartid", data_o, 32'd3);
        check("mhartid legal", 32'(e_illegal_o), 32'd0);
        check("reset int_pending", 32'(int_pending_o), 32'd0);
        check("reset int_cause", int_cause_o, 32'h0);
        check("reset trap_vector", trap_vector_o, 32'h0);
        next();
        read_check("mcycle after reset", 12'hB00, 32'd1);
        read_check("reset mstatus", 12'h300, 32'h0000_1800);
        csr_op(3'b010, 12'h7C0, 5'd0, 32'h0);
        @(negedge clk);
        check("unimplemented illegal", 32'(e_illegal_o), 32'd1);
        next();

        // Vectored mtvec.
        csr_op(3'b001, 12'h305, 5'd5, 32'h8000_0001);
        next();
        do_trap(32'h8000_0007, 32'h400, 32'h0);
        @(negedge clk);
        check("vectored target", trap_vector_o, 32'h8000_001C);
        next();
        do_trap(32'h0000_0002, 32'h404, 32'h0);
        @(negedge clk);
        check("exception target", trap_vector_o, 32'h8000_0000);
        next();

        // Trap entry and mret stacking.
        csr_op(3'b010, 12'h300, 5'd1, 32'h8);
        next();
        do_trap(32'h3, 32'h1002, 32'h0);
        next();
        read_check("mepc aligned", 12'h341, 32'h0000_1000);
        read_check("mstatus after trap", 12'h300, 32'h0000_1880);
        mret_i = 1'b1;
        @(negedge clk);
        check("mret target", trap_vector_o, 32'h0000_1000);
        next();
        read_check("mstatus after mret", 12'h300, 32'h0000_1888);

        // 40-bit counter wrap and read-only write attempt.
        csr_op(3'b001, 12'hB80, 5'd1, 32'hFF);
        next();
        csr_op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF);
        next();
        read_check("mcycleh before wrap", 12'hB80, 32'hFF);
        read_check("mcycle wrapped", 12'hB00, 32'h0);
        read_check("mcycleh wrapped", 12'hB80, 32'h0);
        csr_op(3'b001, 12'hF11, 5'd1, 32'h5);
        @(negedge clk);
        check("read-only write illegal", 32'(e_illegal_o), 32'd1);
        next();
        read_check("mvendorid unchanged", 12'hF11, 32'h0);

        // Interrupt arbitration.
        csr_op(3'b001, 12'h304, 5'd1, 32'h888);
        next();
        csr_op(3'b010, 12'h300, 5'd1, 32'h8);
        irq_i = 3'b111;
        @(negedge clk);
        check("irq not yet registered", 32'(int_pending_o), 32'd0);
        next();
        @(negedge clk);
        check("int_pending", 32'(int_pending_o), 32'd1);
        check("int_cause MEI", int_cause_o, 32'h8000_000B);
        irq_i = 3'b011;
        next();
        @(negedge clk);
        check("int_cause MSI", int_cause_o, 32'h8000_0003);
        irq_i = 3'b000;
        next();

        // Trap beats a CSR instruction; retire still counts.
        csr_op(3'b001, 12'h340, 5'd1, 32'h1234);
        next();
        csr_op(3'b010, 12'h340, 5'd0, 32'hFFFF);
        do_trap(32'h5, 32'h2000, 32'hDEAD);
        retire_i = 1'b1;
        next();
        read_check("mscratch kept", 12'h340, 32'h1234);
        read_check("mcause trap", 12'h342, 32'h5);
        read_check("mtval trap", 12'h343, 32'hDEAD);
        read_check("mepc trap", 12'h341, 32'h2000);
        read_check("minstret retire", 12'hB02, 32'h1);
        csr_op(3'b001, 12'h340, 5'd1, 32'h5555);
        do_trap(32'h6, 32'h3001, 32'hBEEF);
        next();
        read_check("mscratch write dropped", 12'h340, 32'h1234);
        read_check("mcause second trap", 12'h342, 32'h6);

        // Random phase, compared by the compare process every cycle.
        for (int n = 0; n < 1500; n++) begin
            rnd_cycle();
            next();
        end
        rst_i = 1'b0;
        next();
        next();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
